// File: rtl/rs_pkg.sv
// rs_pkg: shared definitions for the age-ordered reservation station.
// Holds parameter defaults, the FU index width and the entry layout used by
// age_ordered_rs and rs_age_matrix. The entry struct is sized by the package
// widths, so a top-level instance must keep TAG_W/DATA_W/ROB_W/NUM_FU at
// these defaults.
package rs_pkg;

  localparam int RS_DEPTH  = 16;
  localparam int RS_NUM_FU = 3;
  localparam int RS_NUM_WK = 4;
  localparam int RS_TAG_W  = 6;
  localparam int RS_DATA_W = 32;
  localparam int RS_ROB_W  = 6;

  // Width of an FU index; a single-FU station still carries one bit.
  localparam int RS_FU_W = (RS_NUM_FU > 1) ? $clog2(RS_NUM_FU) : 1;

  typedef struct packed {
    logic                 valid;
    logic [RS_FU_W-1:0]   fu;
    logic [3:0]           alu_ctrl;
    logic                 ls;
    logic                 alusrc;
    logic [RS_TAG_W-1:0]  rd_tag;
    logic [RS_TAG_W-1:0]  rs1_tag;
    logic [RS_TAG_W-1:0]  rs2_tag;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
    logic [RS_DATA_W-1:0] rs1_val;
    logic [RS_DATA_W-1:0] rs2_val;
    logic [RS_DATA_W-1:0] imm;
    logic [RS_ROB_W-1:0]  rob;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: oldest-requester picker over a shared older-than matrix.
// Ports:
//   older  in  DEPTH x DEPTH  older[j][i]=1 means entry j is older than entry i
//   req    in  DEPTH          requesting entries for one FU
//   grant  out DEPTH          one-hot oldest requester, zero if no request
module rs_age_matrix
  import rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  input  logic [DEPTH-1:0]            req,
  output logic [DEPTH-1:0]            grant
);

  // An entry wins when no other requester is older than it.
  always_comb begin
    logic blocked;
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        blocked = blocked | ((j != i) ? (req[j] & older[j][i]) : 1'b0);
      end
      grant[i] = req[i] & ~blocked;
    end
  end

endmodule

// File: rtl/age_ordered_rs.sv
// age_ordered_rs: unified reservation station with wakeup and per-FU
// oldest-ready issue.
// Ports:
//   clk, reset (sync, active-high), flush      control
//   disp_*  / disp_ready                         dispatch request and handshake
//   fu_ready[NUM_FU]                             per-FU issue acceptance
//   wk_valid / wk_tag / wk_val                   result broadcast ports
//   issue_*                                      registered per-FU issue payload
//   occupancy                                    count of valid entries
module age_ordered_rs
  import rs_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH,
  parameter int NUM_FU = RS_NUM_FU,
  parameter int NUM_WK = RS_NUM_WK,
  parameter int TAG_W  = RS_TAG_W,
  parameter int DATA_W = RS_DATA_W,
  parameter int ROB_W  = RS_ROB_W
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        flush,
  input  logic                                        disp_valid,
  output logic                                        disp_ready,
  input  logic [((NUM_FU > 1) ? $clog2(NUM_FU) : 1)-1:0] disp_fu,
  input  logic [3:0]                                  disp_alu_ctrl,
  input  logic                                        disp_ls,
  input  logic                                        disp_alusrc,
  input  logic [TAG_W-1:0]                            disp_rd_tag,
  input  logic [TAG_W-1:0]                            disp_rs1_tag,
  input  logic [TAG_W-1:0]                            disp_rs2_tag,
  input  logic                                        disp_rs1_rdy,
  input  logic                                        disp_rs2_rdy,
  input  logic [DATA_W-1:0]                           disp_rs1_val,
  input  logic [DATA_W-1:0]                           disp_rs2_val,
  input  logic [DATA_W-1:0]                           disp_imm,
  input  logic [ROB_W-1:0]                            disp_rob,
  input  logic [NUM_FU-1:0]                           fu_ready,
  input  logic [NUM_WK-1:0]                           wk_valid,
  input  logic [NUM_WK*TAG_W-1:0]                     wk_tag,
  input  logic [NUM_WK*DATA_W-1:0]                    wk_val,
  output logic [NUM_FU-1:0]                           issue_valid,
  output logic [NUM_FU-1:0]                           issue_ls,
  output logic [NUM_FU-1:0]                           issue_alusrc,
  output logic [NUM_FU*4-1:0]                         issue_alu_ctrl,
  output logic [NUM_FU*TAG_W-1:0]                     issue_rd_tag,
  output logic [NUM_FU*ROB_W-1:0]                     issue_rob,
  output logic [NUM_FU*DATA_W-1:0]                    issue_rs1_val,
  output logic [NUM_FU*DATA_W-1:0]                    issue_rs2_val,
  output logic [NUM_FU*DATA_W-1:0]                    issue_imm,
  output logic [$clog2(DEPTH):0]                      occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t                     ent     [DEPTH];
  rs_entry_t                     ent_nxt [DEPTH];
  rs_entry_t                     new_ent;
  logic [DEPTH-1:0][DEPTH-1:0]   older;
  logic [DEPTH-1:0][DEPTH-1:0]   older_nxt;
  logic [DEPTH-1:0]              valid_vec;
  logic [DEPTH-1:0]              ready_vec;
  logic [DEPTH-1:0]              removed;
  logic [NUM_FU-1:0][DEPTH-1:0]  req;
  logic [NUM_FU-1:0][DEPTH-1:0]  grant;
  logic [NUM_FU-1:0]             grant_any;
  logic [IDX_W-1:0]              alloc_idx;
  logic                          do_disp;
  logic [CNT_W-1:0]              occ_nxt;
  logic [NUM_FU-1:0]             sel_ls;
  logic [NUM_FU-1:0]             sel_alusrc;
  logic [3:0]                    sel_alu     [NUM_FU];
  logic [TAG_W-1:0]              sel_rd      [NUM_FU];
  logic [ROB_W-1:0]              sel_rob     [NUM_FU];
  logic [DATA_W-1:0]             sel_rs1     [NUM_FU];
  logic [DATA_W-1:0]             sel_rs2     [NUM_FU];
  logic [DATA_W-1:0]             sel_imm     [NUM_FU];

  // Broadcast lookup: {hit, value}; the lowest matching port wins.
  function automatic logic [DATA_W:0] wake_lookup(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] res;
    res = '0;
    for (int p = NUM_WK - 1; p >= 0; p--) begin
      res = (wk_valid[p] && (wk_tag[p*TAG_W +: TAG_W] == tag)) ?
            {1'b1, wk_val[p*DATA_W +: DATA_W]} : res;
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_FU-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      n = n + CNT_W'(v[f]);
    end
    return n;
  endfunction

  assign disp_ready = (occupancy < CNT_W'(DEPTH)) && !flush;
  assign do_disp    = disp_valid && disp_ready;

  // Per-entry status, per-FU requests and lowest free slot.
  always_comb begin
    alloc_idx = '0;
    req       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
      ready_vec[i] = ent[i].valid && ent[i].rs1_rdy && ent[i].rs2_rdy;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alloc_idx = !valid_vec[i] ? IDX_W'(i) : alloc_idx;
    end
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        req[f][i] = ready_vec[i] && (ent[i].fu == RS_FU_W'(f)) && fu_ready[f];
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    rs_age_matrix #(.DEPTH(DEPTH)) u_sel (
      .older (older),
      .req   (req[f]),
      .grant (grant[f])
    );
  end

  // Gather the granted entry's payload for each FU (grants are one-hot).
  always_comb begin
    removed = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      grant_any[f]  = |grant[f];
      removed       = removed | grant[f];
      sel_ls[f]     = 1'b0;
      sel_alusrc[f] = 1'b0;
      sel_alu[f]    = '0;
      sel_rd[f]     = '0;
      sel_rob[f]    = '0;
      sel_rs1[f]    = '0;
      sel_rs2[f]    = '0;
      sel_imm[f]    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        sel_ls[f]     = sel_ls[f]     | (grant[f][i] & ent[i].ls);
        sel_alusrc[f] = sel_alusrc[f] | (grant[f][i] & ent[i].alusrc);
        sel_alu[f]    = sel_alu[f]    | (grant[f][i] ? ent[i].alu_ctrl : 4'd0);
        sel_rd[f]     = sel_rd[f]     | (grant[f][i] ? ent[i].rd_tag  : '0);
        sel_rob[f]    = sel_rob[f]    | (grant[f][i] ? ent[i].rob     : '0);
        sel_rs1[f]    = sel_rs1[f]    | (grant[f][i] ? ent[i].rs1_val : '0);
        sel_rs2[f]    = sel_rs2[f]    | (grant[f][i] ? ent[i].rs2_val : '0);
        sel_imm[f]    = sel_imm[f]    | (grant[f][i] ? ent[i].imm     : '0);
      end
    end
  end

  // Incoming entry; a same-cycle broadcast on a not-ready operand is folded in.
  always_comb begin
    logic [DATA_W:0] w1;
    logic [DATA_W:0] w2;
    w1               = wake_lookup(disp_rs1_tag);
    w2               = wake_lookup(disp_rs2_tag);
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.fu       = disp_fu;
    new_ent.alu_ctrl = disp_alu_ctrl;
    new_ent.ls       = disp_ls;
    new_ent.alusrc   = disp_alusrc;
    new_ent.rd_tag   = disp_rd_tag;
    new_ent.rs1_tag  = disp_rs1_tag;
    new_ent.rs2_tag  = disp_rs2_tag;
    new_ent.rs1_rdy  = disp_rs1_rdy | w1[DATA_W];
    new_ent.rs2_rdy  = disp_rs2_rdy | w2[DATA_W];
    new_ent.rs1_val  = (disp_rs1_rdy || !w1[DATA_W]) ? disp_rs1_val : w1[DATA_W-1:0];
    new_ent.rs2_val  = (disp_rs2_rdy || !w2[DATA_W]) ? disp_rs2_val : w2[DATA_W-1:0];
    new_ent.imm      = disp_imm;
    new_ent.rob      = disp_rob;
  end

  // Entry next state: wakeup capture, removal on issue, dispatch write.
  always_comb begin
    logic [DATA_W:0] w1;
    logic [DATA_W:0] w2;
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = ent[i];
      w1 = wake_lookup(ent[i].rs1_tag);
      w2 = wake_lookup(ent[i].rs2_tag);
      if (ent[i].valid && !ent[i].rs1_rdy && w1[DATA_W]) begin
        ent_nxt[i].rs1_rdy = 1'b1;
        ent_nxt[i].rs1_val = w1[DATA_W-1:0];
      end else begin
        ent_nxt[i].rs1_rdy = ent[i].rs1_rdy;
      end
      if (ent[i].valid && !ent[i].rs2_rdy && w2[DATA_W]) begin
        ent_nxt[i].rs2_rdy = 1'b1;
        ent_nxt[i].rs2_val = w2[DATA_W-1:0];
      end else begin
        ent_nxt[i].rs2_rdy = ent[i].rs2_rdy;
      end
      ent_nxt[i].valid = ent[i].valid && !removed[i];
      ent_nxt[i] = (do_disp && (alloc_idx == IDX_W'(i))) ? new_ent : ent_nxt[i];
    end
  end

  // Age matrix update: the new entry is younger than every surviving entry.
  always_comb begin
    older_nxt = older;
    if (do_disp) begin
      older_nxt[alloc_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        older_nxt[j][alloc_idx] = valid_vec[j] && !removed[j];
      end
    end else begin
      older_nxt = older;
    end
  end

  assign occ_nxt = occupancy + CNT_W'(do_disp) - count_ones(grant_any);

  // Entry storage, age matrix and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
      older     <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= ent_nxt[i];
      end
      older     <= older_nxt;
      occupancy <= occ_nxt;
    end
  end

  // Issue registers; payload holds its last value while not issuing.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid    <= '0;
      issue_ls       <= '0;
      issue_alusrc   <= '0;
      issue_alu_ctrl <= '0;
      issue_rd_tag   <= '0;
      issue_rob      <= '0;
      issue_rs1_val  <= '0;
      issue_rs2_val  <= '0;
      issue_imm      <= '0;
    end else if (flush) begin
      issue_valid <= '0;
    end else begin
      issue_valid <= grant_any;
      for (int f = 0; f < NUM_FU; f++) begin
        if (grant_any[f]) begin
          issue_ls[f]                     <= sel_ls[f];
          issue_alusrc[f]                 <= sel_alusrc[f];
          issue_alu_ctrl[f*4 +: 4]        <= sel_alu[f];
          issue_rd_tag[f*TAG_W +: TAG_W]  <= sel_rd[f];
          issue_rob[f*ROB_W +: ROB_W]     <= sel_rob[f];
          issue_rs1_val[f*DATA_W +: DATA_W] <= sel_rs1[f];
          issue_rs2_val[f*DATA_W +: DATA_W] <= sel_rs2[f];
          issue_imm[f*DATA_W +: DATA_W]   <= sel_imm[f];
        end
      end
    end
  end

endmodule

// File: tb/tb_age_ordered_rs.sv
// tb_age_ordered_rs: directed self-checking bench for age_ordered_rs
// (default parameters: DEPTH=16, NUM_FU=3, NUM_WK=4, 6/32/6-bit fields).
module tb_age_ordered_rs;

  logic        clk = 1'b0;
  logic        reset, flush, disp_valid, disp_ready;
  logic [1:0]  disp_fu;
  logic [3:0]  disp_alu_ctrl;
  logic        disp_ls, disp_alusrc;
  logic [5:0]  disp_rd_tag, disp_rs1_tag, disp_rs2_tag;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_val, disp_rs2_val, disp_imm;
  logic [5:0]  disp_rob;
  logic [2:0]  fu_ready;
  logic [3:0]  wk_valid;
  logic [23:0] wk_tag;
  logic [127:0] wk_val;
  logic [2:0]  issue_valid, issue_ls, issue_alusrc;
  logic [11:0] issue_alu_ctrl;
  logic [17:0] issue_rd_tag, issue_rob;
  logic [95:0] issue_rs1_val, issue_rs2_val, issue_imm;
  logic [4:0]  occupancy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  age_ordered_rs dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
    .disp_alu_ctrl(disp_alu_ctrl), .disp_ls(disp_ls), .disp_alusrc(disp_alusrc),
    .disp_rd_tag(disp_rd_tag), .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val), .disp_imm(disp_imm),
    .disp_rob(disp_rob), .fu_ready(fu_ready),
    .wk_valid(wk_valid), .wk_tag(wk_tag), .wk_val(wk_val),
    .issue_valid(issue_valid), .issue_ls(issue_ls), .issue_alusrc(issue_alusrc),
    .issue_alu_ctrl(issue_alu_ctrl), .issue_rd_tag(issue_rd_tag), .issue_rob(issue_rob),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val), .issue_imm(issue_imm),
    .occupancy(occupancy)
  );

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_disp(input logic [1:0] fu, input logic [5:0] t1, input logic r1,
                            input logic [31:0] v1, input logic [5:0] t2, input logic r2,
                            input logic [31:0] v2, input logic [5:0] rob);
    disp_valid    = 1'b1;
    disp_fu       = fu;
    disp_alu_ctrl = 4'd0;
    disp_ls       = 1'b0;
    disp_alusrc   = 1'b0;
    disp_rd_tag   = rob;
    disp_rs1_tag  = t1;
    disp_rs1_rdy  = r1;
    disp_rs1_val  = v1;
    disp_rs2_tag  = t2;
    disp_rs2_rdy  = r2;
    disp_rs2_val  = v2;
    disp_imm      = v1 ^ 32'hFFFF0000;
    disp_rob      = rob;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; fu_ready = 3'b111; wk_valid = 4'd0; wk_tag = 24'd0; wk_val = 128'd0;
    drive_disp(2'd0, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd9, 6'd0);
    step(); step();
    reset = 1'b0; disp_valid = 1'b0;
    checks++; if (occupancy !== 5'd0) begin fails++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL reset_issue_valid: got %b expected 000", issue_valid); end
    checks++; if (issue_rs1_val !== 96'd0) begin fails++; $display("FAIL reset_payload: got %h expected 0", issue_rs1_val); end
    checks++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL reset_disp_ready: got %b expected 1", disp_ready); end
    step();
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL reset_no_issue: got %b expected 000", issue_valid); end
  endtask

  task automatic test_basic_issue();
    fu_ready = 3'b111;
    drive_disp(2'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 6'd1);
    step();
    disp_valid = 1'b0;
    checks++; if (occupancy !== 5'd1) begin fails++; $display("FAIL basic_occ_disp: got %0d expected 1", occupancy); end
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL basic_early_issue: got %b expected 000", issue_valid); end
    step();
    checks++; if (issue_valid !== 3'b001) begin fails++; $display("FAIL basic_issue_valid: got %b expected 001", issue_valid); end
    checks++; if (issue_rs1_val[31:0] !== 32'd5) begin fails++; $display("FAIL basic_rs1: got %0d expected 5", issue_rs1_val[31:0]); end
    checks++; if (issue_rs2_val[31:0] !== 32'd7) begin fails++; $display("FAIL basic_rs2: got %0d expected 7", issue_rs2_val[31:0]); end
    checks++; if (issue_imm[31:0] !== 32'hFFFF0005) begin fails++; $display("FAIL basic_imm: got %h expected ffff0005", issue_imm[31:0]); end
    checks++; if (issue_rob[5:0] !== 6'd1) begin fails++; $display("FAIL basic_rob: got %0d expected 1", issue_rob[5:0]); end
    checks++; if (occupancy !== 5'd0) begin fails++; $display("FAIL basic_occ_after: got %0d expected 0", occupancy); end
    step();
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL basic_valid_drop: got %b expected 000", issue_valid); end
    checks++; if (issue_rs1_val[31:0] !== 32'd5) begin fails++; $display("FAIL basic_payload_hold: got %0d expected 5", issue_rs1_val[31:0]); end
  endtask

  task automatic test_wakeup();
    fu_ready = 3'b111;
    drive_disp(2'd1, 6'd12, 1'b0, 32'd0, 6'd13, 1'b1, 32'd3, 6'd2);
    step();
    disp_valid = 1'b0;
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL wake_not_ready: got %b expected 000", issue_valid); end
    // Ports 0 and 2 both carry tag 12; port 0 must win.
    wk_valid = 4'b0101; wk_tag = {6'd0, 6'd12, 6'd0, 6'd12};
    wk_val = {32'd0, 32'h0000BEEF, 32'd0, 32'h0000DEAD};
    step();
    wk_valid = 4'd0;
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL wake_capture_edge: got %b expected 000", issue_valid); end
    step();
    checks++; if (issue_valid !== 3'b010) begin fails++; $display("FAIL wake_issue: got %b expected 010", issue_valid); end
    checks++; if (issue_rs1_val[63:32] !== 32'h0000DEAD) begin fails++; $display("FAIL wake_rs1: got %h expected 0000dead", issue_rs1_val[63:32]); end
    checks++; if (issue_rs2_val[63:32] !== 32'd3) begin fails++; $display("FAIL wake_rs2: got %0d expected 3", issue_rs2_val[63:32]); end
    // A broadcast on an already-ready operand must not overwrite it.
    fu_ready = 3'b000;
    drive_disp(2'd0, 6'd30, 1'b1, 32'd55, 6'd31, 1'b1, 32'd66, 6'd3);
    step();
    disp_valid = 1'b0;
    wk_valid = 4'b0001; wk_tag = {18'd0, 6'd30}; wk_val = {96'd0, 32'd99};
    step();
    wk_valid = 4'd0; fu_ready = 3'b001;
    step();
    checks++; if (issue_valid !== 3'b001) begin fails++; $display("FAIL late_wake_issue: got %b expected 001", issue_valid); end
    checks++; if (issue_rs1_val[31:0] !== 32'd55) begin fails++; $display("FAIL late_wake_ignored: got %0d expected 55", issue_rs1_val[31:0]); end
    fu_ready = 3'b111;
    step();
  endtask

  task automatic test_age_order();
    fu_ready = 3'b000;
    drive_disp(2'd0, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1, 6'd4);
    step();
    drive_disp(2'd2, 6'd1, 1'b1, 32'd100, 6'd1, 1'b1, 32'd101, 6'd5);
    step();
    disp_valid = 1'b0; fu_ready = 3'b001;
    step();
    checks++; if (issue_valid !== 3'b001) begin fails++; $display("FAIL age_free_slot: got %b expected 001", issue_valid); end
    // D lands in the freed lower slot but is younger than C.
    fu_ready = 3'b000;
    drive_disp(2'd2, 6'd1, 1'b1, 32'd200, 6'd1, 1'b1, 32'd201, 6'd6);
    step();
    disp_valid = 1'b0;
    checks++; if (occupancy !== 5'd2) begin fails++; $display("FAIL age_occ: got %0d expected 2", occupancy); end
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL age_blocked: got %b expected 000", issue_valid); end
    fu_ready = 3'b100;
    step();
    checks++; if (issue_valid !== 3'b100 || issue_rs1_val[95:64] !== 32'd100) begin fails++; $display("FAIL age_first_c: got valid %b rs1 %0d expected 100/100", issue_valid, issue_rs1_val[95:64]); end
    step();
    checks++; if (issue_valid !== 3'b100 || issue_rs1_val[95:64] !== 32'd200) begin fails++; $display("FAIL age_second_d: got valid %b rs1 %0d expected 100/200", issue_valid, issue_rs1_val[95:64]); end
    step();
    checks++; if (occupancy !== 5'd0) begin fails++; $display("FAIL age_empty: got %0d expected 0", occupancy); end
  endtask

  task automatic test_full();
    fu_ready = 3'b000;
    for (int i = 0; i < 16; i++) begin
      drive_disp(2'(i % 3), 6'd1, 1'b1, 32'(i), 6'd1, 1'b1, 32'(i + 100), 6'(i));
      step();
    end
    checks++; if (occupancy !== 5'd16) begin fails++; $display("FAIL full_occ: got %0d expected 16", occupancy); end
    checks++; if (disp_ready !== 1'b0) begin fails++; $display("FAIL full_disp_ready: got %b expected 0", disp_ready); end
    step();
    checks++; if (occupancy !== 5'd16) begin fails++; $display("FAIL full_no_overflow: got %0d expected 16", occupancy); end
    disp_valid = 1'b0; fu_ready = 3'b111;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (issue_valid !== 3'b111) begin fails++; $display("FAIL full_triple_issue_%0d: got %b expected 111", k, issue_valid); end
      for (int f = 0; f < 3; f++) begin
        checks++; if (issue_rs1_val[f*32 +: 32] !== 32'(3 * k + f)) begin fails++; $display("FAIL full_order_%0d_%0d: got %0d expected %0d", k, f, issue_rs1_val[f*32 +: 32], 3 * k + f); end
      end
      checks++; if (occupancy !== 5'(16 - 3 * (k + 1))) begin fails++; $display("FAIL full_occ_%0d: got %0d expected %0d", k, occupancy, 16 - 3 * (k + 1)); end
      checks++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL full_ready_again_%0d: got %b expected 1", k, disp_ready); end
    end
    step();
    checks++; if (issue_valid !== 3'b001 || issue_rs1_val[31:0] !== 32'd15) begin fails++; $display("FAIL full_last: got valid %b rs1 %0d expected 001/15", issue_valid, issue_rs1_val[31:0]); end
    checks++; if (occupancy !== 5'd0) begin fails++; $display("FAIL full_drained: got %0d expected 0", occupancy); end
    step();
  endtask

  task automatic test_same_cycle_wakeup();
    fu_ready = 3'b111;
    drive_disp(2'd1, 6'd9, 1'b0, 32'd0, 6'd10, 1'b1, 32'd4, 6'd7);
    wk_valid = 4'b0010; wk_tag = {12'd0, 6'd9, 6'd0}; wk_val = {64'd0, 32'h00001234, 32'd0};
    step();
    disp_valid = 1'b0; wk_valid = 4'd0;
    checks++; if (occupancy !== 5'd1) begin fails++; $display("FAIL samecyc_occ: got %0d expected 1", occupancy); end
    step();
    checks++; if (issue_valid !== 3'b010) begin fails++; $display("FAIL samecyc_issue: got %b expected 010", issue_valid); end
    checks++; if (issue_rs1_val[63:32] !== 32'h00001234) begin fails++; $display("FAIL samecyc_rs1: got %h expected 00001234", issue_rs1_val[63:32]); end
    step();
  endtask

  task automatic test_flush();
    fu_ready = 3'b000;
    for (int i = 0; i < 5; i++) begin
      drive_disp(2'd0, 6'd1, 1'b1, 32'(40 + i), 6'd1, 1'b1, 32'd0, 6'(i));
      step();
    end
    checks++; if (occupancy !== 5'd5) begin fails++; $display("FAIL flush_fill: got %0d expected 5", occupancy); end
    flush = 1'b1;
    #1;
    checks++; if (disp_ready !== 1'b0) begin fails++; $display("FAIL flush_blocks_disp: got %b expected 0", disp_ready); end
    step();
    flush = 1'b0; disp_valid = 1'b0;
    checks++; if (occupancy !== 5'd0) begin fails++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
    fu_ready = 3'b111;
    step();
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL flush_no_issue: got %b expected 000", issue_valid); end
    step();
    checks++; if (issue_valid !== 3'b000 || occupancy !== 5'd0) begin fails++; $display("FAIL flush_stays_empty: got %b/%0d expected 000/0", issue_valid, occupancy); end
  endtask

  task automatic test_reset_mid_op();
    fu_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      drive_disp(2'(i), 6'd1, 1'b1, 32'h77, 6'd1, 1'b1, 32'h78, 6'(i));
      step();
    end
    disp_valid = 1'b0; reset = 1'b1; fu_ready = 3'b111;
    step();
    reset = 1'b0;
    checks++; if (occupancy !== 5'd0) begin fails++; $display("FAIL midrst_occ: got %0d expected 0", occupancy); end
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL midrst_valid: got %b expected 000", issue_valid); end
    checks++; if (issue_rs1_val !== 96'd0) begin fails++; $display("FAIL midrst_payload: got %h expected 0", issue_rs1_val); end
    step();
    checks++; if (issue_valid !== 3'b000) begin fails++; $display("FAIL midrst_no_issue: got %b expected 000", issue_valid); end
  endtask

  initial begin
    disp_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_age_order();
    test_full();
    test_same_cycle_wakeup();
    test_flush();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/age_ordered_rs.md
AGE_ORDERED_RS -- requirements
Module: age_ordered_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of 2, 4..64).
REQ-002 SHALL have parameter NUM_FU, default 3, number of issue ports/FUs.
REQ-003 SHALL have parameter NUM_WK, default 4, number of wakeup/broadcast ports.
REQ-004 SHALL have parameters TAG_W=6, DATA_W=32, ROB_W=6: physical tag, operand and ROB index widths.
REQ-005 SHALL have ports:
  clk  in  1  clock, rising edge.
  reset  in  1  reset, synchronous, active-high.
  flush  in  1  discard all entries.
  disp_valid  in  1  dispatch request.
  disp_ready  out  1  entry free, dispatch accepted.
  disp_fu  in  clog2(NUM_FU)  target FU.
  disp_alu_ctrl  in  4  ALU op.
  disp_ls, disp_alusrc  in  1 each  load/store flag, immediate-select flag.
  disp_rd_tag, disp_rs1_tag, disp_rs2_tag  in  TAG_W each  physical tags.
  disp_rs1_rdy, disp_rs2_rdy  in  1 each  operand valid at dispatch.
  disp_rs1_val, disp_rs2_val, disp_imm  in  DATA_W each  operands and immediate.
  disp_rob  in  ROB_W  ROB index.
  fu_ready  in  NUM_FU  FU f accepts an issue this cycle.
  wk_valid  in  NUM_WK;  wk_tag  in  NUM_WK*TAG_W;  wk_val  in  NUM_WK*DATA_W  result broadcasts.
  issue_valid  out  NUM_FU  per-FU issue strobe.
  issue_ls, issue_alusrc  out  NUM_FU;  issue_alu_ctrl  out  NUM_FU*4;  issue_rd_tag  out  NUM_FU*TAG_W;  issue_rob  out  NUM_FU*ROB_W;  issue_rs1_val, issue_rs2_val, issue_imm  out  NUM_FU*DATA_W  issued payload, slice f belongs to FU f.
  occupancy  out  clog2(DEPTH)+1  valid entry count.

Function
REQ-006 disp_ready SHALL equal (occupancy < DEPTH) && !flush, combinationally; a dispatch occurs on a rising edge with disp_valid && disp_ready.
REQ-007 Dispatched instruction SHALL be written into the lowest-index free entry; disp_alu_ctrl==0 SHALL still be a legal op (validity is disp_valid only).
REQ-008 An entry SHALL be ready when valid and both operand-ready bits are set.
REQ-009 Each edge, every valid not-ready operand whose tag matches a valid wk_tag SHALL capture the matching wk_val and set its ready bit; duplicate or late matches on an already-ready operand SHALL be ignored.
REQ-010 A dispatching operand with rdy=0 whose tag matches a wakeup in the same cycle SHALL be stored ready with the broadcast value (no lost wakeup).
REQ-011 Multiple wakeup ports matching one operand SHALL be resolved by lowest port index.
REQ-012 Per FU f, selection SHALL use registered entry state: if fu_ready[f], the oldest ready entry with fu==f SHALL be issued; age = dispatch order, tracked by an age matrix.
REQ-013 Issue outputs SHALL be registered: issue_valid[f] and slice f payload update on the edge the entry is removed; issue_valid[f]=0 if nothing selected; payload SHALL hold its last value when not valid.
REQ-014 Latency: operands ready at dispatch edge E -> issue_valid high after edge E+1; wakeup captured at edge E -> issue_valid high after edge E+1 at earliest.
REQ-015 Up to NUM_FU entries SHALL issue per cycle, at most one per FU.
REQ-016 Slot freed by issue at edge E SHALL be reusable from cycle after E; occupancy SHALL update by (+dispatch - issues) per edge, simultaneous dispatch and issue at full SHALL not occur (disp_ready low).
REQ-017 flush SHALL, at the edge, invalidate all entries, clear age matrix, set occupancy=0, issue_valid=0, and block dispatch that cycle.

Reset
REQ-018 On reset: all entries invalid, age matrix cleared, occupancy=0, issue_valid=0, all issue payload outputs=0; reset SHALL override flush and dispatch.
REQ-019 Reset asserted mid-operation SHALL drop all held entries with no issue after the reset edge.

Structure
REQ-020 Parameter defaults, entry field struct and FU index width SHALL live in shared package rs_pkg.
REQ-021 Oldest-ready selection SHALL be a sub-module rs_age_matrix (DEPTH x DEPTH older-than bits, per-FU request vector in, one-hot grant out), instantiated NUM_FU times sharing one matrix.

Verification
REQ-022 Dispatch A(fu0, both ready, rs1=5, rs2=7) -> issue_valid[0]=1 one edge later, issue_rs1_val=5, issue_rs2_val=7, occupancy back to 0.
REQ-023 Dispatch B(fu1, rs1 tag 12 not ready); next cycle wk_tag0=12, wk_val0=0xDEAD -> B issues on following edge with issue_rs1_val=0xDEAD.
REQ-024 Dispatch C then D, both fu2 ready, fu_ready[2]=0 two cycles then 1 -> C issued first, D next edge.
REQ-025 Fill 16 entries with fu_ready=0 -> disp_ready=0, occupancy=16; raise fu_ready=111 -> three issues per edge, disp_ready=1 after first.
REQ-026 Dispatch tag 9 not ready while wk_tag1=9 same cycle -> entry stored ready, issues next edge; flush with 5 entries -> occupancy=0, no issue_valid afterwards.
